// File: rtl/lcd1602_bus_monitor.sv
// Passive monitor for an HD44780-style LCD bus: it decodes strobed transactions
// into a 2x16 character shadow buffer plus the controller's visible state bits.
module lcd1602_bus_monitor #(
    parameter int DATA_BITS = 8,
    parameter int NUM_CHARS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rs,
    input  logic                 rw,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] data,
    input  logic [4:0]           rd_addr,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 busy,
    output logic                 display_on,
    output logic                 cursor_on,
    output logic                 blink_on,
    output logic                 two_line,
    output logic                 mode_8bit,
    output logic [6:0]           cursor_addr,
    output logic [15:0]          write_count,
    output logic                 err_pulse
);

    localparam int IDX_W = $clog2(NUM_CHARS);
    localparam int BUS_W = DATA_BITS + 2;
    localparam logic [DATA_BITS-1:0] SPACE = 'h20;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHARS - 1);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        CLEAR
    } state_t;

    state_t               state_q, state_d;
    logic                 en_meta_q, en_meta_d;
    logic                 en_sync_q, en_sync_d;
    logic                 en_prev_q, en_prev_d;
    logic [BUS_W-1:0]     bus_s1_q, bus_s1_d;
    logic [BUS_W-1:0]     bus_s2_q, bus_s2_d;
    logic [BUS_W-1:0]     bus_s3_q, bus_s3_d;
    logic [BUS_W-1:0]     cap_q, cap_d;
    logic [DATA_BITS-1:0] chars_q [NUM_CHARS];
    logic [DATA_BITS-1:0] chars_d [NUM_CHARS];
    logic [IDX_W-1:0]     clr_idx_q, clr_idx_d;
    logic [6:0]           cursor_q, cursor_d;
    logic                 id_q, id_d;
    logic                 display_on_q, display_on_d;
    logic                 cursor_on_q, cursor_on_d;
    logic                 blink_on_q, blink_on_d;
    logic                 two_line_q, two_line_d;
    logic                 mode_8bit_q, mode_8bit_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic [15:0]          wc_q, wc_d;
    logic [DATA_BITS-1:0] rd_data_q, rd_data_d;

    logic                 edge_fall;
    logic                 cap_rs;
    logic                 cap_rw;
    logic [DATA_BITS-1:0] cap_data;
    logic [7:0]           cmd;
    logic [4:0]           wr_idx;

    // DDRAM address counter step with the controller's line wrap points.
    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
        logic [6:0] n;
        if (inc) begin
            if (a == 7'h27)      n = 7'h40;
            else if (a == 7'h67) n = 7'h00;
            else                 n = a + 7'd1;
        end else begin
            if (a == 7'h00)      n = 7'h67;
            else if (a == 7'h40) n = 7'h27;
            else                 n = a - 7'd1;
        end
        return n;
    endfunction

    assign cap_rs   = cap_q[BUS_W-1];
    assign cap_rw   = cap_q[BUS_W-2];
    assign cap_data = cap_q[DATA_BITS-1:0];
    assign cmd      = cap_data[7:0];

    always_comb begin
        en_meta_d    = enable;
        en_sync_d    = en_meta_q;
        en_prev_d    = en_sync_q;
        bus_s1_d     = {rs, rw, data};
        bus_s2_d     = bus_s1_q;
        bus_s3_d     = bus_s2_q;
        edge_fall    = en_prev_q & ~en_sync_q;

        state_d      = state_q;
        cap_d        = cap_q;
        chars_d      = chars_q;
        clr_idx_d    = clr_idx_q;
        cursor_d     = cursor_q;
        id_d         = id_q;
        display_on_d = display_on_q;
        cursor_on_d  = cursor_on_q;
        blink_on_d   = blink_on_q;
        two_line_d   = two_line_q;
        mode_8bit_d  = mode_8bit_q;
        busy_d       = busy_q;
        err_d        = 1'b0;
        wc_d         = wc_q;
        rd_data_d    = chars_q[rd_addr];
        wr_idx       = '0;

        // Every captured strobe is counted, whether or not it takes effect.
        if (edge_fall && wc_q != 16'hFFFF) begin
            wc_d = wc_q + 16'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (edge_fall) begin
                    cap_d   = bus_s3_q;
                    state_d = DECODE;
                end
            end

            DECODE: begin
                state_d = IDLE;
                if (edge_fall) begin
                    err_d = 1'b1;
                end
                if (cap_rw) begin
                    err_d = 1'b1;
                end else if (cap_rs) begin
                    if (cursor_q[6:4] == 3'b000) begin
                        wr_idx = {1'b0, cursor_q[3:0]};
                        chars_d[wr_idx] = cap_data;
                    end else if (cursor_q[6:4] == 3'b100) begin
                        wr_idx = {1'b1, cursor_q[3:0]};
                        chars_d[wr_idx] = cap_data;
                    end
                    cursor_d = step_addr(cursor_q, id_q);
                end else if (cmd[7]) begin
                    cursor_d = cmd[6:0];
                end else if (cmd[6]) begin
                    err_d = 1'b1;
                end else if (cmd[5]) begin
                    mode_8bit_d = cmd[4];
                    two_line_d  = cmd[3];
                end else if (cmd[4]) begin
                    if (cmd[3]) err_d = 1'b1;
                    else        cursor_d = step_addr(cursor_q, cmd[2]);
                end else if (cmd[3]) begin
                    display_on_d = cmd[2];
                    cursor_on_d  = cmd[1];
                    blink_on_d   = cmd[0];
                end else if (cmd[2]) begin
                    id_d = cmd[1];
                    if (cmd[0]) err_d = 1'b1;
                end else if (cmd[1]) begin
                    cursor_d = 7'h00;
                end else if (cmd[0]) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                    busy_d    = 1'b1;
                    cursor_d  = 7'h00;
                    id_d      = 1'b1;
                end
            end

            CLEAR: begin
                // Strobes arriving during the sweep are counted and flagged only.
                if (edge_fall) begin
                    err_d = 1'b1;
                end
                chars_d[clr_idx_q] = SPACE;
                if (clr_idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    clr_idx_d = clr_idx_q + IDX_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            en_meta_q    <= 1'b0;
            en_sync_q    <= 1'b0;
            en_prev_q    <= 1'b0;
            bus_s1_q     <= '0;
            bus_s2_q     <= '0;
            bus_s3_q     <= '0;
            cap_q        <= '0;
            for (int i = 0; i < NUM_CHARS; i++) begin
                chars_q[i] <= SPACE;
            end
            clr_idx_q    <= '0;
            cursor_q     <= 7'h00;
            id_q         <= 1'b1;
            display_on_q <= 1'b0;
            cursor_on_q  <= 1'b0;
            blink_on_q   <= 1'b0;
            two_line_q   <= 1'b0;
            mode_8bit_q  <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            wc_q         <= 16'h0000;
            rd_data_q    <= SPACE;
        end else begin
            state_q      <= state_d;
            en_meta_q    <= en_meta_d;
            en_sync_q    <= en_sync_d;
            en_prev_q    <= en_prev_d;
            bus_s1_q     <= bus_s1_d;
            bus_s2_q     <= bus_s2_d;
            bus_s3_q     <= bus_s3_d;
            cap_q        <= cap_d;
            chars_q      <= chars_d;
            clr_idx_q    <= clr_idx_d;
            cursor_q     <= cursor_d;
            id_q         <= id_d;
            display_on_q <= display_on_d;
            cursor_on_q  <= cursor_on_d;
            blink_on_q   <= blink_on_d;
            two_line_q   <= two_line_d;
            mode_8bit_q  <= mode_8bit_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            wc_q         <= wc_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign busy        = busy_q;
    assign display_on  = display_on_q;
    assign cursor_on   = cursor_on_q;
    assign blink_on    = blink_on_q;
    assign two_line    = two_line_q;
    assign mode_8bit   = mode_8bit_q;
    assign cursor_addr = cursor_q;
    assign write_count = wc_q;
    assign err_pulse   = err_q;

endmodule

// File: tb/tb_lcd1602_bus_monitor.sv
// Directed bench for lcd1602_bus_monitor: drives LCD bus strobes and checks
// the shadow buffer and status outputs against hand-computed values.
module tb_lcd1602_bus_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        rs;
    logic        rw;
    logic        enable;
    logic [7:0]  data;
    logic [4:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        busy;
    logic        display_on;
    logic        cursor_on;
    logic        blink_on;
    logic        two_line;
    logic        mode_8bit;
    logic [6:0]  cursor_addr;
    logic [15:0] write_count;
    logic        err_pulse;

    int n_cmp = 0;
    int n_bad = 0;
    int err_seen = 0;
    int busy_cycles = 0;

    lcd1602_bus_monitor #(.DATA_BITS(8), .NUM_CHARS(32)) dut (
        .clk(clk), .reset(reset), .rs(rs), .rw(rw), .enable(enable),
        .data(data), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
        .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .two_line(two_line), .mode_8bit(mode_8bit), .cursor_addr(cursor_addr),
        .write_count(write_count), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (err_pulse === 1'b1) err_seen <= err_seen + 1;
        if (busy === 1'b1) busy_cycles <= busy_cycles + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic r_s, input logic r_w, input logic [7:0] d);
        @(negedge clk);
        rs = r_s; rw = r_w; data = d;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic rd_chk(input string tag, input int a, input logic [7:0] exp);
        logic [4:0] a5;
        a5 = a[4:0];
        @(negedge clk);
        rd_addr = a5;
        @(negedge clk);
        chk($sformatf("%s[%0d]", tag, a), {24'h0, rd_data}, {24'h0, exp});
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'h0, busy}, 32'h0);
    endtask

    task automatic wait_busy(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'h0, busy}, 32'h1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc0;
        int eb;
        reset = 1'b1; rs = 1'b0; rw = 1'b0; enable = 1'b0; data = 8'h00; rd_addr = 5'd0;
        #1;
        chk("rst_cursor", {25'h0, cursor_addr}, 32'h0);
        chk("rst_wcount", {16'h0, write_count}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_err", {31'h0, err_pulse}, 32'h0);
        chk("rst_flags", {27'h0, display_on, cursor_on, blink_on, two_line, mode_8bit}, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rd_chk("rst_rd", 0, 8'h20);

        // Initialisation sequence.
        strobe(1'b0, 1'b0, 8'h38);
        strobe(1'b0, 1'b0, 8'h06);
        strobe(1'b0, 1'b0, 8'h0C);
        bc0 = busy_cycles;
        strobe(1'b0, 1'b0, 8'h01);
        wait_idle("init_idle");
        chk("init_busy_len", busy_cycles - bc0, 32);
        chk("init_mode8", {31'h0, mode_8bit}, 32'h1);
        chk("init_two_line", {31'h0, two_line}, 32'h1);
        chk("init_disp", {29'h0, display_on, cursor_on, blink_on}, 32'h4);
        chk("init_cursor", {25'h0, cursor_addr}, 32'h0);
        chk("init_wcount", {16'h0, write_count}, 32'd4);
        for (int i = 0; i < 32; i++) rd_chk("init_buf", i, 8'h20);

        // Line 1 write at address 0x08.
        strobe(1'b0, 1'b0, 8'h88);
        strobe(1'b1, 1'b0, 8'h31);
        strobe(1'b1, 1'b0, 8'h32);
        rd_chk("l1_buf", 8, 8'h31);
        rd_chk("l1_buf", 9, 8'h32);
        chk("l1_cursor", {25'h0, cursor_addr}, 32'h0A);

        // Full line 2.
        strobe(1'b0, 1'b0, 8'hC0);
        for (int i = 0; i < 16; i++) strobe(1'b1, 1'b0, 8'h41 + 8'(i));
        for (int i = 0; i < 16; i++) rd_chk("l2_buf", 16 + i, 8'h41 + 8'(i));
        chk("l2_cursor", {25'h0, cursor_addr}, 32'h50);
        chk("l2_wcount", {16'h0, write_count}, 32'd24);

        // Off-screen address 0x27 wraps into line 2.
        strobe(1'b0, 1'b0, 8'hA7);
        strobe(1'b1, 1'b0, 8'h58);
        chk("wrap27_cursor", {25'h0, cursor_addr}, 32'h40);
        rd_chk("wrap27_nostore", 16, 8'h41);
        strobe(1'b1, 1'b0, 8'h59);
        rd_chk("wrap27_store", 16, 8'h59);
        chk("wrap27_cursor2", {25'h0, cursor_addr}, 32'h41);
        chk("no_err_yet", err_seen, 0);

        // Display control, return home, decrement mode and shift wraps.
        strobe(1'b0, 1'b0, 8'h0F);
        chk("disp_all", {29'h0, display_on, cursor_on, blink_on}, 32'h7);
        strobe(1'b0, 1'b0, 8'h02);
        chk("home_cursor", {25'h0, cursor_addr}, 32'h0);
        rd_chk("home_buf", 8, 8'h31);
        strobe(1'b0, 1'b0, 8'h04);
        strobe(1'b1, 1'b0, 8'h61);
        rd_chk("dec_buf", 0, 8'h61);
        chk("dec_wrap00", {25'h0, cursor_addr}, 32'h67);
        strobe(1'b0, 1'b0, 8'h14);
        chk("shift_r_wrap67", {25'h0, cursor_addr}, 32'h00);
        strobe(1'b0, 1'b0, 8'h10);
        chk("shift_l_wrap00", {25'h0, cursor_addr}, 32'h67);
        strobe(1'b0, 1'b0, 8'hC0);
        strobe(1'b0, 1'b0, 8'h10);
        chk("shift_l_wrap40", {25'h0, cursor_addr}, 32'h27);
        strobe(1'b0, 1'b0, 8'h06);
        strobe(1'b0, 1'b0, 8'hE7);
        strobe(1'b1, 1'b0, 8'h62);
        chk("inc_wrap67", {25'h0, cursor_addr}, 32'h00);
        rd_chk("offscreen_nostore", 0, 8'h61);

        // Unsupported commands.
        eb = err_seen;
        strobe(1'b0, 1'b0, 8'h05);
        strobe(1'b0, 1'b0, 8'h1C);
        strobe(1'b0, 1'b0, 8'h48);
        strobe(1'b0, 1'b0, 8'h06);
        chk("unsup_errs", err_seen - eb, 3);
        chk("unsup_cursor", {25'h0, cursor_addr}, 32'h00);
        rd_chk("unsup_buf", 0, 8'h61);
        strobe(1'b0, 1'b0, 8'h20);
        chk("func_set", {30'h0, mode_8bit, two_line}, 32'h0);
        chk("wcount_mid", {16'h0, write_count}, 32'd43);

        // Data strobe dropped while a clear is running.
        do_reset();
        strobe(1'b0, 1'b0, 8'h01);
        wait_busy("drop_busy");
        eb = err_seen;
        strobe(1'b1, 1'b0, 8'h5A);
        wait_idle("drop_idle");
        chk("drop_err", err_seen - eb, 1);
        chk("drop_wcount", {16'h0, write_count}, 32'd2);
        chk("drop_cursor", {25'h0, cursor_addr}, 32'h0);
        for (int i = 0; i < 32; i++) rd_chk("drop_buf", i, 8'h20);

        // Read strobe, then reset in the middle of a clear.
        strobe(1'b0, 1'b0, 8'hCF);
        strobe(1'b1, 1'b0, 8'h5A);
        rd_chk("pre_rst_buf", 31, 8'h5A);
        eb = err_seen;
        strobe(1'b0, 1'b1, 8'h80);
        chk("rw_err", err_seen - eb, 1);
        chk("rw_cursor", {25'h0, cursor_addr}, 32'h50);
        chk("rw_wcount", {16'h0, write_count}, 32'd5);
        strobe(1'b0, 1'b0, 8'h38);
        strobe(1'b0, 1'b0, 8'h0F);
        strobe(1'b0, 1'b0, 8'h01);
        chk("midclr_busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_cursor", {25'h0, cursor_addr}, 32'h0);
        chk("abort_wcount", {16'h0, write_count}, 32'h0);
        chk("abort_err", {31'h0, err_pulse}, 32'h0);
        chk("abort_flags", {27'h0, display_on, cursor_on, blink_on, two_line, mode_8bit}, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rd_chk("abort_buf", 31, 8'h20);
        rd_chk("abort_buf", 20, 8'h20);
        chk("abort_wcount2", {16'h0, write_count}, 32'h0);
        strobe(1'b1, 1'b0, 8'h41);
        rd_chk("post_rst_buf", 0, 8'h41);
        chk("post_rst_cursor", {25'h0, cursor_addr}, 32'h01);
        chk("post_rst_wcount", {16'h0, write_count}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
